// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: memory-port types, owner encoding and arbiter defaults.
package mem_arbiter_pkg;
   localparam int MEM_NUM_TAGS     = 16;
   localparam int MEM_STARVE_LIMIT = 4;
   typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} MEM_COMMAND;
   typedef enum logic {OWNER_ICACHE, OWNER_DCACHE} MEM_OWNER;
   typedef logic [31:0] ADDR;
   typedef logic [63:0] MEM_BLOCK;
   typedef logic [$clog2(MEM_NUM_TAGS)-1:0] MEM_TAG;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/dcache request, memory port and routed-response bundle.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;
   MEM_COMMAND icache_command;
   ADDR        icache_addr;
   MEM_COMMAND dcache_command;
   ADDR        dcache_addr;
   MEM_BLOCK   dcache_data;
   MEM_TAG     mem2proc_transaction_tag;
   MEM_BLOCK   mem2proc_data;
   MEM_TAG     mem2proc_data_tag;
   MEM_COMMAND proc2mem_command;
   ADDR        proc2mem_addr;
   MEM_BLOCK   proc2mem_data;
   MEM_TAG     icache_transaction_tag;
   MEM_TAG     dcache_transaction_tag;
   MEM_TAG     icache_data_tag;
   MEM_TAG     dcache_data_tag;
   MEM_BLOCK   icache_data;
   MEM_BLOCK   dcache_data_out;
   logic       err_orphan;
   modport slave (
      input  icache_command, icache_addr, dcache_command, dcache_addr, dcache_data,
             mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
             icache_transaction_tag, dcache_transaction_tag,
             icache_data_tag, dcache_data_tag, icache_data, dcache_data_out, err_orphan
   );
   modport master (
      output icache_command, icache_addr, dcache_command, dcache_addr, dcache_data,
             mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
             icache_transaction_tag, dcache_transaction_tag,
             icache_data_tag, dcache_data_tag, icache_data, dcache_data_out, err_orphan
   );
endinterface

// File: rtl/mem_arbiter_tag_owner_table.sv
// tag_owner_table: per-tag {valid, owner} record of outstanding loads.
// A clear and a set of the same tag in one cycle leaves the new owner valid.
module tag_owner_table
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_TAGS = MEM_NUM_TAGS
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     i_set,
   input  MEM_TAG   i_set_tag,
   input  MEM_OWNER i_set_owner,
   input  logic     i_clr,
   input  MEM_TAG   i_clr_tag,
   input  MEM_TAG   i_lk_tag,
   output logic     o_lk_valid,
   output MEM_OWNER o_lk_owner
);
   logic [NUM_TAGS-1:0] r_valid;
   MEM_OWNER            r_owner [NUM_TAGS];

   always_ff @(posedge clock) begin
      if (reset) r_valid <= '0;
      else begin
         if (i_clr) r_valid[i_clr_tag] <= 1'b0;
         if (i_set) r_valid[i_set_tag] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (i_set) r_owner[i_set_tag] <= i_set_owner;
   end

   assign o_lk_valid = r_valid[i_lk_tag];
   assign o_lk_owner = r_owner[i_lk_tag];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory port between icache and dcache, dcache first,
// with an aging counter that hands the port to a starved icache.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_TAGS     = MEM_NUM_TAGS,
   parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   logic [SW-1:0] r_starve_cnt;
   logic          r_err_orphan;
   logic          w_i_req, w_d_req, w_grant_i, w_grant_d, w_accept;
   logic          w_rsp, w_hit, w_lk_valid;
   MEM_OWNER      w_lk_owner;

   assign w_i_req   = bus.icache_command != MEM_NONE;
   assign w_d_req   = bus.dcache_command != MEM_NONE;
   assign w_grant_i = w_i_req && (!w_d_req || r_starve_cnt == LIM);
   assign w_grant_d = w_d_req && !w_grant_i;
   assign w_accept  = (w_grant_i || w_grant_d) && bus.mem2proc_transaction_tag != '0;

   assign bus.proc2mem_command = w_grant_i ? bus.icache_command :
                                 w_grant_d ? bus.dcache_command : MEM_NONE;
   assign bus.proc2mem_addr    = w_grant_i ? bus.icache_addr :
                                 w_grant_d ? bus.dcache_addr : '0;
   assign bus.proc2mem_data    = w_grant_d ? bus.dcache_data : '0;
   assign bus.icache_transaction_tag = w_grant_i ? bus.mem2proc_transaction_tag : '0;
   assign bus.dcache_transaction_tag = w_grant_d ? bus.mem2proc_transaction_tag : '0;

   tag_owner_table #(.NUM_TAGS(NUM_TAGS)) u_table (
      .clock       (clock),
      .reset       (reset),
      .i_set       (w_accept && bus.proc2mem_command == MEM_LOAD),
      .i_set_tag   (bus.mem2proc_transaction_tag),
      .i_set_owner (w_grant_i ? OWNER_ICACHE : OWNER_DCACHE),
      .i_clr       (w_hit),
      .i_clr_tag   (bus.mem2proc_data_tag),
      .i_lk_tag    (bus.mem2proc_data_tag),
      .o_lk_valid  (w_lk_valid),
      .o_lk_owner  (w_lk_owner)
   );

   assign w_rsp = bus.mem2proc_data_tag != '0;
   assign w_hit = w_rsp && w_lk_valid;
   assign bus.icache_data_tag = (w_hit && w_lk_owner == OWNER_ICACHE) ? bus.mem2proc_data_tag : '0;
   assign bus.dcache_data_tag = (w_hit && w_lk_owner == OWNER_DCACHE) ? bus.mem2proc_data_tag : '0;
   assign bus.icache_data     = bus.mem2proc_data;
   assign bus.dcache_data_out = bus.mem2proc_data;
   assign bus.err_orphan      = r_err_orphan;

   // Only accepted dcache traffic ages the icache; a busy memory holds the count.
   always_ff @(posedge clock) begin
      if (reset) r_starve_cnt <= '0;
      else if (!w_i_req || (w_grant_i && w_accept)) r_starve_cnt <= '0;
      else if (w_grant_d && w_accept && r_starve_cnt != LIM) r_starve_cnt <= r_starve_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) r_err_orphan <= 1'b0;
      else if (w_rsp && !w_lk_valid) r_err_orphan <= 1'b1;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic against a queue-based scoreboard.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;
   localparam int STARVE = MEM_STARVE_LIMIT;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_arbiter_if bus();
   mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus.slave));

   typedef struct {
      MEM_COMMAND cmd;
      ADDR        addr;
      MEM_BLOCK   data;
      MEM_TAG     itag, dtag, idt, ddt;
      MEM_BLOCK   rdata;
      logic       err;
   } exp_t;

   exp_t     q[$];
   MEM_OWNER own[int];
   bit       err_m;
   int       lost;
   int       n_cmp = 0, n_bad = 0;

   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endfunction

   // Monitor: every cycle with an expectation, compare all outputs mid-cycle.
   initial forever begin
      @(negedge clock);
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("cmd",   64'(bus.proc2mem_command), 64'(e.cmd));
         chk("addr",  64'(bus.proc2mem_addr), 64'(e.addr));
         chk("pdata", bus.proc2mem_data, e.data);
         chk("itag",  64'(bus.icache_transaction_tag), 64'(e.itag));
         chk("dtag",  64'(bus.dcache_transaction_tag), 64'(e.dtag));
         chk("idtag", 64'(bus.icache_data_tag), 64'(e.idt));
         chk("ddtag", 64'(bus.dcache_data_tag), 64'(e.ddt));
         chk("idata", bus.icache_data, e.rdata);
         chk("ddata", bus.dcache_data_out, e.rdata);
         chk("err",   64'(bus.err_orphan), 64'(e.err));
      end
   end

   task automatic idle_inputs();
      bus.icache_command = MEM_NONE;
      bus.dcache_command = MEM_NONE;
      bus.icache_addr = '0;
      bus.dcache_addr = '0;
      bus.dcache_data = '0;
      bus.mem2proc_transaction_tag = '0;
      bus.mem2proc_data = '0;
      bus.mem2proc_data_tag = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      own.delete();
      err_m = 1'b0;
      lost = 0;
   endtask

   // One clock of traffic: predict from the arbitration rules, push, drive, advance.
   task automatic cycle(MEM_COMMAND ic, ADDR ia, MEM_COMMAND dc, ADDR da, MEM_BLOCK dd,
                        MEM_TAG mt_in, MEM_TAG rt, MEM_BLOCK rd);
      exp_t e;
      bit iq, dq, gi, gd, acc;
      MEM_TAG mt;
      iq = ic != MEM_NONE;
      dq = dc != MEM_NONE;
      gi = iq && (!dq || lost >= STARVE);
      gd = dq && !gi;
      mt = (gi || gd) ? mt_in : MEM_TAG'(0);
      acc = mt != 0;
      e.cmd   = gi ? ic : (gd ? dc : MEM_NONE);
      e.addr  = gi ? ia : (gd ? da : ADDR'(0));
      e.data  = gd ? dd : MEM_BLOCK'(0);
      e.itag  = gi ? mt : MEM_TAG'(0);
      e.dtag  = gd ? mt : MEM_TAG'(0);
      e.idt   = (rt != 0 && own.exists(int'(rt)) && own[int'(rt)] == OWNER_ICACHE) ? rt : MEM_TAG'(0);
      e.ddt   = (rt != 0 && own.exists(int'(rt)) && own[int'(rt)] == OWNER_DCACHE) ? rt : MEM_TAG'(0);
      e.rdata = rd;
      e.err   = err_m;
      q.push_back(e);
      bus.icache_command = ic;
      bus.icache_addr = ia;
      bus.dcache_command = dc;
      bus.dcache_addr = da;
      bus.dcache_data = dd;
      bus.mem2proc_transaction_tag = mt;
      bus.mem2proc_data = rd;
      bus.mem2proc_data_tag = rt;
      if (rt != 0) begin
         if (own.exists(int'(rt))) own.delete(int'(rt));
         else err_m = 1'b1;
      end
      if (acc && e.cmd == MEM_LOAD) own[int'(mt)] = gi ? OWNER_ICACHE : OWNER_DCACHE;
      if (!iq || (gi && acc)) lost = 0;
      else if (gd && acc && lost < STARVE) lost++;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_rsp(MEM_TAG rt);
      cycle(MEM_NONE, $urandom, MEM_NONE, $urandom, {$urandom, $urandom}, '0, rt, {$urandom, $urandom});
   endtask

   task automatic both_load(MEM_TAG mt);
      cycle(MEM_LOAD, $urandom, MEM_LOAD, $urandom, {$urandom, $urandom}, mt, '0, '0);
   endtask

   function automatic MEM_TAG pick_free(MEM_TAG rt);
      MEM_TAG f[$];
      for (int t = 1; t < MEM_NUM_TAGS; t++)
         if (!own.exists(t) || t == int'(rt)) f.push_back(MEM_TAG'(t));
      return f.size() > 0 ? f[$urandom_range(f.size() - 1)] : MEM_TAG'(0);
   endfunction

   function automatic MEM_TAG pick_owned();
      MEM_TAG k[$];
      foreach (own[t]) k.push_back(MEM_TAG'(t));
      return k.size() > 0 ? k[$urandom_range(k.size() - 1)] : MEM_TAG'(0);
   endfunction

   initial begin
      do_reset();
      idle_rsp('0);
      for (int n = 0; n < 600; n++) begin
         MEM_COMMAND ic, dc;
         MEM_TAG rt, mt;
         int r;
         ic = ($urandom_range(9) < 6) ? MEM_LOAD : MEM_NONE;
         r = $urandom_range(9);
         dc = r < 3 ? MEM_NONE : (r < 7 ? MEM_LOAD : MEM_STORE);
         r = $urandom_range(19);
         rt = r < 9 ? pick_owned() : (r == 9 ? MEM_TAG'($urandom_range(15, 1)) : MEM_TAG'(0));
         mt = ($urandom_range(3) != 0) ? pick_free(rt) : MEM_TAG'(0);
         cycle(ic, $urandom, dc, $urandom, {$urandom, $urandom}, mt, rt, {$urandom, $urandom});
      end
      do_reset();
      cycle(MEM_LOAD, 32'h1000, MEM_NONE, '0, '0, 4'd3, '0, '0);
      repeat (4) idle_rsp('0);
      idle_rsp(4'd3);
      idle_rsp(4'd3);
      idle_rsp('0);
      do_reset();
      for (int t = 1; t <= 5; t++) both_load(MEM_TAG'(t));
      both_load(4'd6);
      for (int t = 1; t <= 6; t++) idle_rsp(MEM_TAG'(t));
      cycle(MEM_NONE, '0, MEM_LOAD, 32'h2000, '0, 4'd5, '0, '0);
      cycle(MEM_LOAD, 32'h3000, MEM_NONE, '0, '0, 4'd6, '0, '0);
      idle_rsp(4'd6);
      idle_rsp(4'd5);
      cycle(MEM_NONE, '0, MEM_STORE, 32'h4000, 64'hDEAD_BEEF_0123_4567, 4'd7, '0, '0);
      idle_rsp(4'd7);
      idle_rsp('0);
      do_reset();
      for (int t = 1; t <= 3; t++) both_load(MEM_TAG'(t));
      repeat (3) both_load('0);
      both_load(4'd4);
      both_load(4'd5);
      for (int t = 1; t <= 5; t++) idle_rsp(MEM_TAG'(t));
      cycle(MEM_LOAD, 32'h5000, MEM_NONE, '0, '0, 4'd2, '0, '0);
      cycle(MEM_NONE, '0, MEM_LOAD, 32'h6000, '0, 4'd4, '0, '0);
      do_reset();
      idle_rsp(4'd2);
      idle_rsp('0);
      idle_inputs();
      @(negedge clock);
      @(negedge clock);
      chk("drain", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
